// File: rtl/ascii_dec_parser.sv
// Streaming ASCII decimal to binary converter: accumulates digit characters and
// emits the saturated binary value, overflow flag and digit count on a delimiter.
module ascii_dec_parser #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [7:0]       char_in,
   input  logic             char_valid,
   output logic             char_ready,
   output logic [WIDTH-1:0] value,
   output logic             value_valid,
   input  logic             value_ready,
   output logic             overflow,
   output logic [CNT_W-1:0] digit_count
);

   localparam int EXT_W = WIDTH + 4;
   localparam logic [EXT_W-1:0] MAX_EXT = {4'b0000, {WIDTH{1'b1}}};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] acc_reg;
   logic             ovf_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             char_ready_reg;
   logic             value_valid_reg;
   logic [WIDTH-1:0] value_reg;
   logic             overflow_reg;
   logic [CNT_W-1:0] digit_count_reg;

   logic             is_digit;
   logic [3:0]       digit;
   logic             accept;
   logic [EXT_W-1:0] acc_ext;
   logic [EXT_W-1:0] digit_ext;
   logic [EXT_W-1:0] sum_next;
   logic             first_ovf_next;
   logic [WIDTH-1:0] first_acc_next;
   logic             ovf_next;
   logic [WIDTH-1:0] acc_next;
   logic [CNT_W-1:0] cnt_next;

   // The low nibble of '0'..'9' is the digit value itself.
   assign is_digit = (char_in[7:4] == 4'h3) && (char_in[3:0] <= 4'd9);
   assign digit    = char_in[3:0];
   assign accept   = char_valid && char_ready_reg;

   always_comb begin
      acc_ext   = {4'b0000, acc_reg};
      digit_ext = {{WIDTH{1'b0}}, digit};
      // acc*10 as shift-and-add; WIDTH+4 bits cannot wrap for acc*10+9.
      sum_next  = (acc_ext << 3) + (acc_ext << 1) + digit_ext;

      ovf_next = ovf_reg || (sum_next > MAX_EXT);
      acc_next = ovf_next ? {WIDTH{1'b1}} : sum_next[WIDTH-1:0];

      // Only matters for narrow WIDTH where a single digit can exceed the range.
      first_ovf_next = (digit_ext > MAX_EXT);
      first_acc_next = first_ovf_next ? {WIDTH{1'b1}} : digit_ext[WIDTH-1:0];

      cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= IDLE;
         acc_reg         <= '0;
         ovf_reg         <= 1'b0;
         cnt_reg         <= '0;
         char_ready_reg  <= 1'b1;
         value_valid_reg <= 1'b0;
         value_reg       <= '0;
         overflow_reg    <= 1'b0;
         digit_count_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept && is_digit) begin
                  acc_reg   <= first_acc_next;
                  ovf_reg   <= first_ovf_next;
                  cnt_reg   <= CNT_ONE;
                  state_reg <= ACCUM;
               end
            end
            ACCUM: begin
               if (accept) begin
                  if (is_digit) begin
                     acc_reg <= acc_next;
                     ovf_reg <= ovf_next;
                     cnt_reg <= cnt_next;
                  end else begin
                     value_reg       <= acc_reg;
                     overflow_reg    <= ovf_reg;
                     digit_count_reg <= cnt_reg;
                     value_valid_reg <= 1'b1;
                     char_ready_reg  <= 1'b0;
                     state_reg       <= DONE;
                  end
               end
            end
            DONE: begin
               if (value_ready) begin
                  value_valid_reg <= 1'b0;
                  char_ready_reg  <= 1'b1;
                  acc_reg         <= '0;
                  ovf_reg         <= 1'b0;
                  cnt_reg         <= '0;
                  state_reg       <= IDLE;
               end
            end
            default: begin
               value_valid_reg <= 1'b0;
               char_ready_reg  <= 1'b1;
               state_reg       <= IDLE;
            end
         endcase
      end
   end

   assign char_ready  = char_ready_reg;
   assign value_valid = value_valid_reg;
   assign value       = value_reg;
   assign overflow    = overflow_reg;
   assign digit_count = digit_count_reg;

endmodule

// File: tb/tb_ascii_dec_parser.sv
// Bench for ascii_dec_parser: directed cases plus random character streams,
// checked against a string-level decimal reference model.
module tb_ascii_dec_parser;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;
   localparam longint MAXV = (64'd1 << WIDTH) - 1;
   localparam int CMAX = (1 << CNT_W) - 1;

   typedef logic [7:0] ch_t;
   typedef struct {
      longint val;
      bit     ovf;
      int     cnt;
   } res_t;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic [7:0]       char_in = 8'h00;
   logic             char_valid = 1'b0;
   logic             char_ready;
   logic [WIDTH-1:0] value;
   logic             value_valid;
   logic             value_ready = 1'b0;
   logic             overflow;
   logic [CNT_W-1:0] digit_count;

   ascii_dec_parser #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .char_in     (char_in),
      .char_valid  (char_valid),
      .char_ready  (char_ready),
      .value       (value),
      .value_valid (value_valid),
      .value_ready (value_ready),
      .overflow    (overflow),
      .digit_count (digit_count)
   );

   always #5 clock = ~clock;

   int nvec = 0;
   int nerr = 0;

   ch_t  digits_q[$];
   res_t exp_q[$];
   bit   lat_pending = 0;
   bit   prev_valid = 0;
   bit   prev_hs = 0;
   logic [WIDTH-1:0] prev_value = '0;
   int   hold_cnt = 0;
   bit   force_hi = 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic bit is_dig(input ch_t c);
      return (c >= 8'h30) && (c <= 8'h39);
   endfunction

   // Evaluates the whole digit string as a number, then applies saturation.
   function automatic res_t eval_number();
      res_t   r;
      longint n = 0;
      foreach (digits_q[i]) n = n * 10 + longint'(digits_q[i] - 8'h30);
      r.ovf = (n > MAXV);
      r.val = r.ovf ? MAXV : n;
      r.cnt = (digits_q.size() > CMAX) ? CMAX : digits_q.size();
      return r;
   endfunction

   task automatic model_accept(input ch_t c);
      if (is_dig(c)) begin
         digits_q.push_back(c);
      end else if (digits_q.size() > 0) begin
         exp_q.push_back(eval_number());
         digits_q.delete();
         lat_pending = 1;
      end
   endtask

   task automatic observe();
      res_t r;
      bit   hs;
      if (!reset_n) return;
      check("ready_vs_valid", char_ready, !value_valid);
      if (lat_pending) begin
         check("latency", value_valid, 1);
         lat_pending = 0;
      end
      if (prev_hs) begin
         check("valid_drop", value_valid, 0);
      end else if (prev_valid) begin
         check("hold_valid", value_valid, 1);
         check("hold_value", value, prev_value);
      end
      if (hold_cnt > 0) begin
         value_ready = 1'b0;
         hold_cnt--;
      end else begin
         value_ready = force_hi ? 1'b1 : ($urandom_range(0, 2) == 0);
      end
      hs = value_valid && value_ready;
      if (hs) begin
         if (exp_q.size() == 0) begin
            check("spurious_valid", value_valid, 0);
         end else begin
            r = exp_q.pop_front();
            check("value", value, r.val);
            check("overflow", overflow, r.ovf);
            check("digit_count", digit_count, r.cnt);
         end
      end
      prev_hs    = hs;
      prev_valid = value_valid;
      prev_value = value;
   endtask

   task automatic tick();
      @(negedge clock);
      observe();
   endtask

   task automatic send(input ch_t c, output int waits);
      waits = 0;
      tick();
      char_in    = c;
      char_valid = 1'b1;
      while (!char_ready && waits < 200) begin
         tick();
         waits++;
      end
      if (!char_ready) check("ready_timeout", char_ready, 1);
      else model_accept(c);
   endtask

   task automatic send1(input ch_t c);
      int w;
      send(c, w);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send1(ch_t'(s[i]));
   endtask

   task automatic gap(input int k);
      repeat (k) begin
         tick();
         char_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      force_hi = 1;
      tick();
      char_valid = 1'b0;
      while ((exp_q.size() > 0 || value_valid) && n < 50) begin
         tick();
         n++;
      end
      check("drain_pending", exp_q.size(), 0);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
   task automatic async_reset();
      char_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("arst_char_ready", char_ready, 1);
      check("arst_value_valid", value_valid, 0);
      check("arst_value", value, 0);
      check("arst_overflow", overflow, 0);
      check("arst_digit_count", digit_count, 0);
      digits_q.delete();
      exp_q.delete();
      lat_pending = 0;
      prev_valid  = 0;
      prev_hs     = 0;
      hold_cnt    = 0;
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   function automatic ch_t rand_nondigit();
      ch_t b;
      do b = ch_t'($urandom_range(0, 255)); while (is_dig(b));
      return b;
   endfunction

   function automatic ch_t rand_delim();
      case ($urandom_range(0, 6))
         0: return 8'h20;
         1: return 8'h0D;
         2: return 8'h0A;
         3: return 8'h2C;
         4: return 8'h2B;
         5: return 8'h2D;
         default: return rand_nondigit();
      endcase
   endfunction

   initial begin
      int w;
      int k;
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_char_ready", char_ready, 1);
      check("rst_value_valid", value_valid, 0);
      check("rst_value", value, 0);
      check("rst_overflow", overflow, 0);
      check("rst_digit_count", digit_count, 0);
      reset_n = 1'b1;

      force_hi = 1;
      send_str("255 ");
      drain();

      send_str("256");
      send1(8'h0D);
      send_str("9999,");
      drain();

      send_str("  0042");
      send1(8'h0A);
      drain();

      send_str("00000000000000007 ");
      drain();

      // Consumer stalls 5 cycles; next char waits for the handshake.
      send_str("7;");
      hold_cnt = 5;
      send(8'h38, w);
      check("wait_after_hs", w, 6);
      send1(8'h20);
      drain();

      send_str("12");
      tick();
      async_reset();
      send_str("3.");
      drain();

      // Pending result discarded by reset while in DONE.
      send_str("5,");
      hold_cnt = 10;
      tick();
      tick();
      async_reset();
      send_str("-+6?");
      drain();

      send1(8'h31);
      gap(2);
      send1(8'h39);
      send1(8'h78);
      drain();

      force_hi = 0;
      for (int t = 0; t < 60; t++) begin
         repeat ($urandom_range(0, 2)) send1(rand_delim());
         k = ($urandom_range(0, 9) < 7) ? $urandom_range(1, 4) : $urandom_range(1, 18);
         for (int d = 0; d < k; d++) begin
            send1(ch_t'(8'h30 + $urandom_range(0, 9)));
            if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
         end
         if ($urandom_range(0, 7) == 0) hold_cnt = $urandom_range(1, 6);
         send1(rand_delim());
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/ascii_dec_parser.md
Name: ascii_dec_parser

Overview:
Streaming decoder that converts ASCII decimal digit characters into a binary value. It is the reverse path of the team's binary-to-ASCII BCD display converter. It sits between the text/UART receive path and the control logic: it accepts one character per handshake, accumulates a decimal number, and emits the binary result when a non-digit delimiter arrives. Out-of-range numbers saturate and raise an overflow flag.

Parameters:
WIDTH, 8, width of the binary result; maximum representable value is 2^WIDTH-1.
CNT_W, 4, width of the digit counter output; saturates at 2^CNT_W-1.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
char_in  input  8  ASCII character.
char_valid  input  1  char_in is valid this cycle.
char_ready  output  1  parser can accept a character; a transfer occurs when char_valid and char_ready are both 1.
value  output  WIDTH  parsed binary value; stable while value_valid=1.
value_valid  output  1  result available.
value_ready  input  1  consumer accepts the result; handshake completes when value_valid and value_ready are both 1.
overflow  output  1  result saturated; qualified by value_valid.
digit_count  output  CNT_W  number of digits consumed for this result, including leading zeros; qualified by value_valid.

Behaviour:
- Reset (async assert on reset_n=0, release synchronous to clock):
  - state=IDLE, accumulator=0, sticky overflow=0, digit counter=0.
  - Outputs: char_ready=1, value_valid=0, value=0, overflow=0, digit_count=0.
- Digit: char_in in 0x30..0x39; digit value = char_in-0x30. Any other byte is a non-digit.
- State IDLE: char_ready=1.
  - Accepted non-digit: ignored (leading whitespace or delimiters are skipped).
  - Accepted digit: acc=digit, cnt=1 -> ACCUM.
- State ACCUM: char_ready=1.
  - Accepted digit: next = acc*10 + digit, computed in WIDTH+4 bits.
    - If next > 2^WIDTH-1 or sticky overflow is already set: acc=2^WIDTH-1 and ovf=1.
    - Otherwise acc=next.
    - cnt increments, saturating at 2^CNT_W-1.
  - Accepted non-digit: the delimiter is consumed, not forwarded. Latch value=acc, overflow=ovf, digit_count=cnt -> DONE.
- State DONE: char_ready=0, value_valid=1, and value/overflow/digit_count are held.
  - On value_valid & value_ready: clear acc/ovf/cnt -> IDLE.
  - value_valid deasserts and char_ready asserts in the cycle after the handshake.
- Latency: value_valid rises on the first clock edge after the delimiter is accepted. Minimum period from delimiter to the next accepted character is 2 cycles when value_ready is tied high.
- No idle cycles inside a number: back-to-back digits are accepted every cycle.
- char_valid=0 holds state; a number spanning gaps in char_valid is legal.
- A leading '-' or '+' is treated as a non-digit; signed numbers are unsupported.
- Reset mid-number or mid-DONE: all partial state is discarded and the pending result is lost. No output pulse is produced.
- value_ready asserted outside DONE has no effect.
- Outputs are registered; there is no combinational path from char_in or value_ready to any output except char_ready, which is driven from state only.

Test Plan:
- '2','5','5',' ' with value_ready=1 -> value=255, overflow=0, digit_count=3, value_valid high for 1 cycle, one cycle after ' '.
- '2','5','6',0x0D -> value=255, overflow=1, digit_count=3; then '9','9','9','9',',' -> value=255, overflow=1, digit_count=4.
- ' ',' ','0','0','4','2',0x0A -> value=42, overflow=0, digit_count=4; the leading spaces produce no output.
- '7',';' with value_ready=0 for 5 cycles and char_valid held high with '8' -> char_ready=0, value=7 held stable; after the handshake, '8' is accepted in the following cycle.
- '1','2', then reset_n low for 1 cycle, then '3','.' -> value=3, digit_count=1; no output before the reset.
- Digits interleaved with char_valid=0 gaps ('1',gap,gap,'9','x') -> value=19, overflow=0, digit_count=2.
